// File: rtl/operand_master.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module     : operand_master
// Description: Avalon-MM master that writes two operands, then reads a result
//              word a programmable number of times with fixed read latency.
// Revision   : 1.0 - initial release
//------------------------------------------------------------------------------
module operand_master #(
   parameter int         WIDTH        = 32,
   parameter int         READ_LATENCY = 1,
   parameter logic [3:0] A_ADDR       = 4'h0,
   parameter logic [3:0] B_ADDR       = 4'h4,
   parameter logic [3:0] O_ADDR       = 4'h8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic [7:0]       read_count,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             result_valid,
   output logic [3:0]       master_address,
   output logic             master_read,
   output logic             master_write,
   output logic [WIDTH-1:0] master_writedata,
   input  logic [WIDTH-1:0] master_readdata,
   input  logic             master_waitrequest
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR_A    = 3'd1,
      WR_B    = 3'd2,
      RD      = 3'd3,
      RD_WAIT = 3'd4
   } state_t;

   localparam logic [2:0] LAT_LAST = 3'(READ_LATENCY - 1);

   state_t           state_q;
   logic [WIDTH-1:0] b_q;
   logic [7:0]       cnt_q;
   logic [2:0]       lat_q;
   logic             busy_q;
   logic             done_q;
   logic [WIDTH-1:0] result_q;
   logic             rv_q;
   logic [3:0]       addr_q;
   logic             read_q;
   logic             write_q;
   logic [WIDTH-1:0] wdata_q;

   // The write-data register doubles as the latch for operand A.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         b_q      <= '0;
         cnt_q    <= '0;
         lat_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
         rv_q     <= 1'b0;
         addr_q   <= '0;
         read_q   <= 1'b0;
         write_q  <= 1'b0;
         wdata_q  <= '0;
      end else begin
         done_q <= 1'b0;
         rv_q   <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  b_q     <= op_b;
                  cnt_q   <= read_count;
                  busy_q  <= 1'b1;
                  write_q <= 1'b1;
                  addr_q  <= A_ADDR;
                  wdata_q <= op_a;
                  state_q <= WR_A;
               end
            end
            WR_A: begin
               if (!master_waitrequest) begin
                  addr_q  <= B_ADDR;
                  wdata_q <= b_q;
                  state_q <= WR_B;
               end
            end
            WR_B: begin
               if (!master_waitrequest) begin
                  write_q <= 1'b0;
                  wdata_q <= '0;
                  if (cnt_q != 8'd0) begin
                     read_q  <= 1'b1;
                     addr_q  <= O_ADDR;
                     state_q <= RD;
                  end else begin
                     addr_q  <= '0;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= IDLE;
                  end
               end
            end
            RD: begin
               if (!master_waitrequest) begin
                  read_q  <= 1'b0;
                  addr_q  <= '0;
                  cnt_q   <= cnt_q - 8'd1;
                  lat_q   <= '0;
                  state_q <= RD_WAIT;
               end
            end
            RD_WAIT: begin
               if (lat_q == LAT_LAST) begin
                  result_q <= master_readdata;
                  rv_q     <= 1'b1;
                  if (cnt_q != 8'd0) begin
                     read_q  <= 1'b1;
                     addr_q  <= O_ADDR;
                     state_q <= RD;
                  end else begin
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= IDLE;
                  end
               end else begin
                  lat_q <= lat_q + 3'd1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy             = busy_q;
   assign done             = done_q;
   assign result           = result_q;
   assign result_valid     = rv_q;
   assign master_address   = addr_q;
   assign master_read      = read_q;
   assign master_write     = write_q;
   assign master_writedata = wdata_q;

endmodule
`default_nettype wire
